// File: rtl/clock_pkg.sv
// Shared definitions for the time-set controller: field encodings, BCD
// field limits, the commit FSM state type and BCD step helpers.
package clock_pkg;

  typedef enum logic [1:0] {
    FIELD_HOUR   = 2'd0,
    FIELD_MINUTE = 2'd1,
    FIELD_SECOND = 2'd2,
    FIELD_MIL    = 2'd3
  } field_e;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINUTE_MAX = 8'h59;
  localparam logic [7:0] SECOND_MAX = 8'h59;
  localparam logic [7:0] MIL_MAX    = 8'h99;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } commit_state_e;

  // Largest legal BCD value of a field.
  function automatic logic [7:0] field_max(input field_e f);
    case (f)
      FIELD_HOUR:   return HOUR_MAX;
      FIELD_MINUTE: return MINUTE_MAX;
      FIELD_SECOND: return SECOND_MAX;
      default:      return MIL_MAX;
    endcase
  endfunction

  // BCD +1 with units carry; the field maximum wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    if (v == vmax)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                    return v + 8'd1;
  endfunction

  // BCD -1 with units borrow; 00 wraps to the field maximum.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
    if (v == 8'h00)          return vmax;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                     return v - 8'd1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One pushbutton: 2-FF synchronizer, stability-counter debouncer and a
// single-cycle press pulse on the debounced released-to-pressed edge.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]     sync_q;
  logic           level_q;
  logic [DCW-1:0] cnt_q;
  logic           sample;

  // Sampled key in pressed-high polarity.
  assign sample = ~sync_q[1];

  // Bring the raw key into the clock domain; idles at released (high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], key_n};
  end

  // Flip the debounced level only after a full run of differing samples.
  // NOTE: state registers use non-blocking assignments so every flop sees
  // the pre-edge values of the others, exactly as the hardware does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sample == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_LAST) begin
        level_q <= sample;
        cnt_q   <= '0;
        press   <= sample;
      end else begin
        cnt_q <= cnt_q + DCW'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time/alarm set controller: four BCD edit buffers adjusted by debounced
// keys, and a commit FSM that writes hour, minute, second, mil in turn to
// the clock core using select levels and a time or alarm write strobe.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STROBE_CYCLES   = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  input  logic       key_dec_n,
  input  logic       key_commit_n,
  input  logic       sw_alarm,
  output logic [7:0] time_in,
  output logic       set_hour,
  output logic       set_minute,
  output logic       set_second,
  output logic       set_mil,
  output logic       set_time,
  output logic       set_alarm,
  output logic [1:0] edit_field,
  output logic [7:0] edit_value,
  output logic       busy
);

  localparam int SCW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [SCW-1:0] STROBE_LAST = SCW'(STROBE_CYCLES - 1);

  logic mode_ev, inc_ev, dec_ev, commit_ev;
  logic [1:0] sw_sync_q;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(CLOCK_50), .rst_n(reset_n), .key_n(key_mode_n), .press(mode_ev));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(CLOCK_50), .rst_n(reset_n), .key_n(key_inc_n), .press(inc_ev));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk(CLOCK_50), .rst_n(reset_n), .key_n(key_dec_n), .press(dec_ev));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_commit (
    .clk(CLOCK_50), .rst_n(reset_n), .key_n(key_commit_n), .press(commit_ev));

  // Synchronize the alarm/time target switch (no debounce needed).
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) sw_sync_q <= 2'b00;
    else          sw_sync_q <= {sw_sync_q[0], sw_alarm};
  end

  // ---------------------------------------------------------------- edit
  commit_state_e state_q, state_next;
  logic [7:0]    edit_buf_q    [4];
  logic [7:0]    edit_buf_next [4];
  field_e        field_q, field_next;

  // Apply mode/inc/dec events to the field pointer and selected buffer.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    edit_buf_next = edit_buf_q;
    field_next    = field_q;
    if (state_q == ST_IDLE) begin
      if (mode_ev) field_next = field_e'(field_q + 2'd1);
      if (inc_ev && !dec_ev)
        edit_buf_next[field_q] = bcd_inc(edit_buf_q[field_q], field_max(field_q));
      else if (dec_ev && !inc_ev)
        edit_buf_next[field_q] = bcd_dec(edit_buf_q[field_q], field_max(field_q));
    end
  end

  // Edit buffers, field pointer and the registered view of the buffer.
  // NOTE: this small buffer array is reset element by element because a
  // defined 00 after reset is part of its behaviour; larger storage
  // arrays without such a need are normally left unreset.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) edit_buf_q[i] <= 8'h00;
      field_q    <= FIELD_HOUR;
      edit_value <= 8'h00;
    end else begin
      edit_buf_q <= edit_buf_next;
      field_q    <= field_next;
      edit_value <= edit_buf_next[field_next];
    end
  end

  assign edit_field = field_q;

  // ---------------------------------------------------------- commit FSM
  logic [1:0]     idx_q, idx_next;
  logic [SCW-1:0] cnt_q, cnt_next;
  logic           target_q, target_next;

  // State register with field index, strobe counter and latched target.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      target_q <= 1'b0;
    end else begin
      state_q  <= state_next;
      idx_q    <= idx_next;
      cnt_q    <= cnt_next;
      target_q <= target_next;
    end
  end

  // Next-state: SETUP (1) -> STROBE (STROBE_CYCLES) -> HOLD (1) per field.
  always_comb begin
    state_next  = state_q;
    idx_next    = idx_q;
    cnt_next    = cnt_q;
    target_next = target_q;
    case (state_q)
      ST_IDLE: begin
        if (commit_ev) begin
          state_next  = ST_SETUP;
          idx_next    = 2'd0;
          target_next = sw_sync_q[1];
        end
      end
      ST_SETUP: begin
        state_next = ST_STROBE;
        cnt_next   = '0;
      end
      ST_STROBE: begin
        if (cnt_q == STROBE_LAST) state_next = ST_HOLD;
        else                      cnt_next   = cnt_q + SCW'(1);
      end
      ST_HOLD: begin
        if (idx_q == 2'd3) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_SETUP;
          idx_next   = idx_q + 2'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  logic [7:0] time_in_next;
  logic [3:0] sel_next, sel_q;
  logic       set_time_next, set_alarm_next, busy_next;

  // Output values for the coming state, so the registered outputs line up
  // with the state they describe.
  always_comb begin
    time_in_next   = 8'h00;
    sel_next       = 4'b0000;
    set_time_next  = 1'b0;
    set_alarm_next = 1'b0;
    busy_next      = (state_next != ST_IDLE);
    if (state_next != ST_IDLE) begin
      time_in_next = edit_buf_next[idx_next];
      sel_next     = 4'b0001 << idx_next;
    end
    if (state_next == ST_STROBE) begin
      set_time_next  = ~target_next;
      set_alarm_next = target_next;
    end
  end

  // Output registers toward the clock core.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      time_in   <= 8'h00;
      sel_q     <= 4'b0000;
      set_time  <= 1'b0;
      set_alarm <= 1'b0;
      busy      <= 1'b0;
    end else begin
      time_in   <= time_in_next;
      sel_q     <= sel_next;
      set_time  <= set_time_next;
      set_alarm <= set_alarm_next;
      busy      <= busy_next;
    end
  end

  assign set_hour   = sel_q[0];
  assign set_minute = sel_q[1];
  assign set_second = sel_q[2];
  assign set_mil    = sel_q[3];

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl with short debounce; edit buffers are modelled
// as plain decimal integers and converted to BCD only for comparison.
module tb_time_set_ctrl;

  localparam int DB  = 4;
  localparam int SC  = 2;
  localparam int REC = 48;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_mode_n = 1'b1, key_inc_n = 1'b1, key_dec_n = 1'b1, key_commit_n = 1'b1;
  logic       sw_alarm = 1'b0;
  logic [7:0] time_in, edit_value;
  logic       set_hour, set_minute, set_second, set_mil, set_time, set_alarm, busy;
  logic [1:0] edit_field;

  time_set_ctrl #(.DEBOUNCE_CYCLES(DB), .STROBE_CYCLES(SC)) dut (
    .CLOCK_50(clk), .reset_n(reset_n),
    .key_mode_n(key_mode_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
    .key_commit_n(key_commit_n), .sw_alarm(sw_alarm),
    .time_in(time_in), .set_hour(set_hour), .set_minute(set_minute),
    .set_second(set_second), .set_mil(set_mil), .set_time(set_time),
    .set_alarm(set_alarm), .edit_field(edit_field), .edit_value(edit_value),
    .busy(busy));

  always #10 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: decimal field values and current field index.
  int mdl_val [4];
  int mdl_field;
  int mdl_max [4] = '{23, 59, 59, 99};

  logic       rec_busy [REC];
  logic       rec_st   [REC];
  logic       rec_sa   [REC];
  logic [7:0] rec_ti   [REC];
  logic [3:0] rec_sel  [REC];

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic strb(input bit alarm, input int n);
    return alarm ? rec_sa[n] : rec_st[n];
  endfunction

  function automatic void mdl_reset();
    for (int i = 0; i < 4; i++) mdl_val[i] = 0;
    mdl_field = 0;
  endfunction

  // Press the chosen keys together, release, then compare the edit view.
  task automatic press(input bit m, input bit i, input bit d);
    @(posedge clk); #1;
    if (m) key_mode_n = 1'b0;
    if (i) key_inc_n  = 1'b0;
    if (d) key_dec_n  = 1'b0;
    repeat (10) @(posedge clk); #1;
    key_mode_n = 1'b1; key_inc_n = 1'b1; key_dec_n = 1'b1;
    repeat (10) @(posedge clk);
    if (i && !d) mdl_val[mdl_field] = (mdl_val[mdl_field] + 1) % (mdl_max[mdl_field] + 1);
    if (d && !i) mdl_val[mdl_field] = (mdl_val[mdl_field] + mdl_max[mdl_field]) % (mdl_max[mdl_field] + 1);
    if (m) mdl_field = (mdl_field + 1) % 4;
    @(negedge clk);
    vectors++;
    if (edit_field !== 2'(mdl_field) || edit_value !== to_bcd(mdl_val[mdl_field])) begin
      errors++;
      $display("FAIL edit_after_press: field=%0d value=%h, expected field=%0d value=%h",
               edit_field, edit_value, mdl_field, to_bcd(mdl_val[mdl_field]));
    end
  endtask

  task automatic go_field(input int f);
    for (int k = 0; k < 4 && mdl_field != f; k++) press(1'b1, 1'b0, 1'b0);
  endtask

  // Step the current field to v along the shorter direction.
  task automatic set_value(input int v);
    for (int k = 0; k < 100 && mdl_val[mdl_field] != v; k++) begin
      int span, up;
      span = mdl_max[mdl_field] + 1;
      up   = (v - mdl_val[mdl_field] + span) % span;
      if (up <= span - up) press(1'b0, 1'b1, 1'b0);
      else                 press(1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({set_time, set_alarm, set_hour, set_minute, set_second, set_mil, busy} !== 7'd0 ||
        time_in !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b time_in=%h, expected all 0",
               {set_time, set_alarm, set_hour, set_minute, set_second, set_mil, busy}, time_in);
    end
    vectors++;
    if (edit_field !== 2'd0 || edit_value !== 8'h00) begin
      errors++;
      $display("FAIL reset_edit: field=%0d value=%h, expected 0/00", edit_field, edit_value);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    mdl_reset();
    repeat (20) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (edit_value !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: value=%h busy=%b, expected 00/0", edit_value, busy);
    end
  endtask

  task automatic test_hour_wrap;
    go_field(0);
    set_value(23);
    press(1'b0, 1'b1, 1'b0);
    vectors++;
    if (edit_value !== 8'h00) begin
      errors++; $display("FAIL hour_inc_wrap: got %h, expected 00", edit_value);
    end
    press(1'b0, 1'b0, 1'b1);
    vectors++;
    if (edit_value !== 8'h23) begin
      errors++; $display("FAIL hour_dec_wrap: got %h, expected 23", edit_value);
    end
  endtask

  task automatic test_carry_borrow;
    go_field(1);
    set_value(9);
    press(1'b0, 1'b1, 1'b0);
    vectors++;
    if (edit_value !== 8'h10) begin
      errors++; $display("FAIL minute_carry: got %h, expected 10", edit_value);
    end
    set_value(0);
    press(1'b0, 1'b0, 1'b1);
    vectors++;
    if (edit_value !== 8'h59) begin
      errors++; $display("FAIL minute_borrow_wrap: got %h, expected 59", edit_value);
    end
    go_field(3);
    set_value(99);
    press(1'b0, 1'b1, 1'b0);
    vectors++;
    if (edit_value !== 8'h00) begin
      errors++; $display("FAIL mil_wrap: got %h, expected 00", edit_value);
    end
  endtask

  task automatic test_inc_dec_same;
    set_value(37);
    press(1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_bounce;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1 key_inc_n = k[0];
      @(posedge clk);
    end
    #1 key_inc_n = 1'b0;
    repeat (10) @(posedge clk); #1 key_inc_n = 1'b1;
    repeat (10) @(posedge clk);
    mdl_val[mdl_field] = (mdl_val[mdl_field] + 1) % (mdl_max[mdl_field] + 1);
    @(negedge clk);
    vectors++;
    if (edit_value !== to_bcd(mdl_val[mdl_field])) begin
      errors++;
      $display("FAIL bounce_single_inc: got %h, expected %h", edit_value, to_bcd(mdl_val[mdl_field]));
    end
  endtask

  task automatic test_random_edit;
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0:       press(1'b1, 1'b0, 1'b0);
        1:       press(1'b0, 1'b1, 1'b0);
        2:       press(1'b0, 1'b0, 1'b1);
        default: press(1'b0, 1'b1, 1'b1);
      endcase
    end
  endtask

  // Press commit and record outputs each cycle; optional mid-run stimulus.
  task automatic record_commit(input int inc_at, input int sw_at);
    @(posedge clk); #1 key_commit_n = 1'b0;
    for (int n = 0; n < REC; n++) begin
      if (n == inc_at) key_inc_n = 1'b0;
      if (n == sw_at)  sw_alarm  = ~sw_alarm;
      @(negedge clk);
      rec_busy[n] = busy;
      rec_st[n]   = set_time;
      rec_sa[n]   = set_alarm;
      rec_ti[n]   = time_in;
      rec_sel[n]  = {set_mil, set_second, set_minute, set_hour};
      @(posedge clk); #1;
    end
    key_commit_n = 1'b1; key_inc_n = 1'b1;
    repeat (12) @(posedge clk);
  endtask

  task automatic analyze(input bit alarm);
    int first_busy, last_busy, nbusy, nrise, nwrong;
    first_busy = -1; last_busy = -1; nbusy = 0; nrise = 0; nwrong = 0;
    for (int n = 0; n < REC; n++) begin
      if (rec_busy[n]) begin
        if (first_busy < 0) first_busy = n;
        last_busy = n;
        nbusy++;
      end
      if (strb(!alarm, n)) nwrong++;
    end
    vectors++;
    if (nbusy != 4 * (SC + 2) || last_busy - first_busy + 1 != 4 * (SC + 2)) begin
      errors++;
      $display("FAIL busy_window: %0d busy cycles over span %0d, expected %0d contiguous",
               nbusy, last_busy - first_busy + 1, 4 * (SC + 2));
    end
    vectors++;
    if (nwrong != 0) begin
      errors++; $display("FAIL wrong_strobe: other strobe high %0d cycles, expected 0", nwrong);
    end
    for (int n = 1; n < REC; n++) begin
      if (strb(alarm, n) && !strb(alarm, n - 1)) begin
        if (nrise < 4) begin
          logic [7:0] exp_ti;
          logic [3:0] exp_sel;
          int j;
          exp_ti  = to_bcd(mdl_val[nrise]);
          exp_sel = 4'b0001 << nrise;
          vectors++;
          if (rec_ti[n] !== exp_ti || rec_sel[n] !== exp_sel) begin
            errors++;
            $display("FAIL strobe_data[%0d]: time_in=%h sel=%b, expected %h/%b",
                     nrise, rec_ti[n], rec_sel[n], exp_ti, exp_sel);
          end
          vectors++;
          if (rec_ti[n-1] !== exp_ti || rec_sel[n-1] !== exp_sel) begin
            errors++;
            $display("FAIL setup_before[%0d]: time_in=%h sel=%b, expected %h/%b",
                     nrise, rec_ti[n-1], rec_sel[n-1], exp_ti, exp_sel);
          end
          j = n;
          while (j < REC && strb(alarm, j)) j++;
          vectors++;
          if (j >= REC || j - n != SC || rec_sel[j] !== exp_sel || rec_ti[j] !== exp_ti) begin
            errors++;
            $display("FAIL hold_after[%0d]: width=%0d, expected %0d with %h/%b held",
                     nrise, j - n, SC, exp_ti, exp_sel);
          end
        end
        nrise++;
      end
    end
    vectors++;
    if (nrise != 4) begin
      errors++; $display("FAIL strobe_count: got %0d rising edges, expected 4", nrise);
    end
    vectors++;
    if (last_busy < 0 || last_busy + 1 >= REC ||
        rec_sel[last_busy+1] !== 4'b0000 || rec_ti[last_busy+1] !== 8'h00) begin
      errors++; $display("FAIL idle_after_commit: selects or time_in not cleared, expected 0/00");
    end
  endtask

  task automatic test_commit_time;
    go_field(0); set_value(12);
    go_field(1); set_value(34);
    go_field(2); set_value(56);
    go_field(3); set_value(78);
    sw_alarm = 1'b0;
    repeat (4) @(posedge clk);
    record_commit(-1, -1);
    analyze(1'b0);
  endtask

  task automatic test_commit_alarm;
    sw_alarm = 1'b1;
    repeat (4) @(posedge clk);
    record_commit(3, 12);
    analyze(1'b1);
    @(negedge clk);
    vectors++;
    if (edit_value !== to_bcd(mdl_val[mdl_field])) begin
      errors++;
      $display("FAIL inc_while_busy: got %h, expected %h", edit_value, to_bcd(mdl_val[mdl_field]));
    end
    sw_alarm = 1'b0;
  endtask

  task automatic test_reset_mid_commit;
    bit seen;
    int nb;
    seen = 1'b0;
    @(posedge clk); #1 key_commit_n = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (set_time && set_minute) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      errors++; $display("FAIL minute_strobe_timeout: seen=0, expected 1");
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({set_time, set_alarm, set_hour, set_minute, set_second, set_mil, busy} !== 7'd0 ||
        time_in !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_commit: ctl=%b time_in=%h, expected all 0",
               {set_time, set_alarm, set_hour, set_minute, set_second, set_mil, busy}, time_in);
    end
    vectors++;
    if (edit_field !== 2'd0 || edit_value !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_edit: field=%0d value=%h, expected 0/00", edit_field, edit_value);
    end
    key_commit_n = 1'b1;
    repeat (3) @(posedge clk); #1 reset_n = 1'b1;
    mdl_reset();
    nb = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) nb++;
    end
    vectors++;
    if (nb != 0 || edit_value !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_quiet: busy cycles=%0d value=%h, expected 0/00", nb, edit_value);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hour_wrap();
    test_carry_borrow();
    test_inc_dec_same();
    test_bounce();
    test_random_edit();
    test_commit_time();
    test_commit_alarm();
    test_reset_mid_commit();
    press(1'b0, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: number of stable CLOCK_50 cycles a button must hold before its debounced level changes (10 ms at 50 MHz).
REQ-002 Parameter STROBE_CYCLES, default 2: number of cycles set_time/set_alarm stay high per field write.
REQ-003 CLOCK_50  input  1  the single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 key_mode_n, key_inc_n, key_dec_n, key_commit_n  input  1 each  raw active-low pushbuttons, asynchronous to CLOCK_50.
REQ-006 sw_alarm  input  1  switch; 1 = commit writes alarm, 0 = commit writes time.
REQ-007 time_in  output  8  BCD pair (tens [7:4], units [3:0]) presented to the clock core.
REQ-008 set_hour, set_minute, set_second, set_mil  output  1 each  field-select levels to the clock core; at most one high at a time.
REQ-009 set_time, set_alarm  output  1 each  write strobes; the core latches on their rising edge.
REQ-010 edit_field  output  2  field being edited: 0 hour, 1 minute, 2 second, 3 mil.
REQ-011 edit_value  output  8  BCD contents of the edit buffer for edit_field.
REQ-012 busy  output  1  high while a commit sequence is in progress.

Function
REQ-013 Each key SHALL pass through a 2-FF synchronizer, then a debouncer that updates its level only after DEBOUNCE_CYCLES consecutive identical samples; sw_alarm SHALL be 2-FF synchronized only.
REQ-014 A press event SHALL be a one-cycle pulse on the debounced released-to-pressed transition; holding a key SHALL produce no further events.
REQ-015 Four 8-bit BCD edit buffers SHALL hold hour (00-23), minute (00-59), second (00-59), mil (00-99).
REQ-016 A mode event in IDLE SHALL advance edit_field 0->1->2->3->0.
REQ-017 An inc event SHALL add 1 to the selected buffer in BCD with a units carry at 9; the field maximum wraps to 00 (23->00, 59->00, 99->00).
REQ-018 A dec event SHALL subtract 1 in BCD with a units borrow at 0; 00 wraps to the field maximum.
REQ-019 Inc and dec events in the same cycle SHALL leave the buffer unchanged.
REQ-020 Mode, inc and dec events SHALL be ignored while busy=1.
REQ-021 A commit event in IDLE SHALL latch sw_alarm as the target for the whole sequence and write all four fields in the order hour, minute, second, mil.
REQ-022 The commit FSM SHALL have states IDLE, SETUP, STROBE and HOLD, with a 2-bit field index.
REQ-023 SETUP, 1 cycle: drive time_in with the buffer and raise the matching set_<field>; the strobe is low.
REQ-024 STROBE, STROBE_CYCLES cycles: time_in and the select stay as in SETUP; set_time (target 0) or set_alarm (target 1) is high.
REQ-025 HOLD, 1 cycle: the strobe is low and time_in and the select are held; the FSM then goes to SETUP for the next field, or to IDLE after mil.
REQ-026 With commit accepted in cycle N, busy SHALL be high for cycles N+1 to N+4*(STROBE_CYCLES+2) and low after that; all selects SHALL be low in IDLE.
REQ-027 A commit event while busy SHALL be ignored.
REQ-028 time_in SHALL be 00 in IDLE.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 reset_n low SHALL immediately force all strobes and selects to 0, time_in=00, busy=0, edit_field=0, all buffers to 00, debouncers to released, and the FSM to IDLE, including during a commit.
REQ-031 After reset_n rises, no press event SHALL be generated unless a key is pressed for DEBOUNCE_CYCLES.

Structure
REQ-032 Package clock_pkg SHALL contain the field encodings, the field maximums (8'h23, 8'h59, 8'h59, 8'h99) and the commit state typedef.
REQ-033 Sub-module button_debounce (synchronizer, debounce counter, press pulse) SHALL be instantiated once per key.

Verification (DEBOUNCE_CYCLES=4, STROBE_CYCLES=2)
REQ-034 Hour buffer 23, key_inc press -> edit_value=00; then key_dec press -> 23.
REQ-035 Mode to minute, buffer 09, inc -> 10; buffer 00, dec -> 59; mil 99, inc -> 00.
REQ-036 key_inc bouncing every 2 cycles for 20 cycles then held low -> exactly one increment.
REQ-037 Buffers 12/34/56/78, sw_alarm=0, commit -> four set_time rising edges, each with time_in 12, 34, 56, 78 and the matching select stable one cycle before and after; busy high for 16 cycles; set_alarm never high.
REQ-038 Same commit with sw_alarm toggled mid-sequence -> the target does not change; inc pressed during busy -> buffer unchanged.
REQ-039 reset_n low during the STROBE of minute -> set_time and all selects low in the same cycle, buffers 00, edit_field 0.
